// File: rtl/fifo_nibble_serializer_if.sv
// Bundle of FIFO read-port, control and serial-line signals for the nibble serializer.
interface fifo_nibble_serializer_if #(
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  en;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_rinc;
  logic                  tx;
  logic                  busy;
  logic                  frame_done;
  logic [7:0]            words_sent;

  // Serializer side
  modport slave (
    input  en, fifo_empty, fifo_rdata,
    output fifo_rinc, tx, busy, frame_done, words_sent
  );

  // Environment side (FIFO + control)
  modport master (
    output en, fifo_empty, fifo_rdata,
    input  fifo_rinc, tx, busy, frame_done, words_sent
  );
endinterface

// File: rtl/fifo_nibble_serializer.sv
// Pops FIFO words and sends each as a serial frame: start, data LSB first,
// optional even parity, stop. tx idles high.
module fifo_nibble_serializer #(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fifo_nibble_serializer_if.slave    bus
);

  localparam int unsigned BAUD_W = 8;
  localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      words_q, words_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pop_c;
  logic                  baud_last;

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      words_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      words_q <= words_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, bit timing, and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    words_d = words_q;
    pop_c   = 1'b0;
    tx_d    = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    if (state_q != IDLE) begin
      baud_d = baud_last ? '0 : BAUD_W'(baud_q + BAUD_W'(1));
    end

    case (state_q)
      IDLE: begin
        // Reset gating keeps the pop strobe quiet while rst_n is held low
        if (rst_n && bus.en && !bus.fifo_empty) begin
          pop_c   = 1'b1;
          shift_d = bus.fifo_rdata;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) state_d = DATA;
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = BIT_W'(bit_q + BIT_W'(1));
          end
        end
      end
      PARITY: begin
        if (baud_last) state_d = STOP;
      end
      STOP: begin
        if (baud_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are looked up from the upcoming state so they line up with it
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
      PARITY:  tx_d = ^shift_d;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == BAUD_W'(CLKS_PER_BIT - 1));
    if (done_d) words_d = CNT_W'(words_q + CNT_W'(1));
  end

  assign bus.fifo_rinc  = pop_c;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.words_sent = words_q;

endmodule

// File: tb/tb_fifo_nibble_serializer.sv
// Scoreboard bench for fifo_nibble_serializer (DATA_WIDTH=4, CLKS_PER_BIT=4, even parity).
module tb_fifo_nibble_serializer;

  logic clk;
  logic rst_n;
  logic en;

  logic [3:0] fmem [16];
  logic [3:0] rd_ptr;
  logic [3:0] wr_ptr;
  logic       pop_pend;

  int tests;
  int fails;
  int cyc;
  int frames_seen;
  int pop_log[$];
  logic [6:0] exp_q[$];

  logic        rec;
  int          idx;
  logic [28:0] txrec;
  logic [28:0] busyrec;

  fifo_nibble_serializer_if #(.DATA_WIDTH(4)) ifc ();

  assign ifc.en         = en;
  assign ifc.fifo_empty = (rd_ptr == wr_ptr);
  assign ifc.fifo_rdata = fmem[rd_ptr];

  fifo_nibble_serializer #(
    .DATA_WIDTH  (4),
    .CLKS_PER_BIT(4),
    .PARITY_EN   (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // FIFO model: the word is removed just after the clock edge that ends the pop cycle
  always @(negedge clk) pop_pend = ifc.fifo_rinc;
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      rd_ptr   = rd_ptr + 4'd1;
      pop_pend = 1'b0;
    end
  end

  // Monitor: records each frame from its pop and scores it on frame_done
  always @(negedge clk) begin
    logic [6:0]  pat;
    logic [28:0] expv;
    cyc++;
    if (!rst_n) begin
      rec = 1'b0;
    end else begin
      if (ifc.fifo_rinc) begin
        pop_log.push_back(cyc);
        chk("rinc_legal", {31'd0, ifc.fifo_empty | ifc.busy}, 32'd0);
        rec = 1'b1; idx = 0; txrec = '0; busyrec = '0;
      end else if (rec) begin
        idx++;
        if (idx <= 28) begin
          txrec[idx]   = ifc.tx;
          busyrec[idx] = ifc.busy;
        end
        if (idx > 40) begin
          chk("frame_timeout", 32'(idx), 32'd28);
          rec = 1'b0;
        end
      end
      if (ifc.frame_done) begin
        if (!rec || exp_q.size() == 0) begin
          chk("unexpected_frame_done", {31'd0, rec}, 32'd2);
        end else begin
          pat  = exp_q.pop_front();
          expv = '0;
          for (int i = 1; i <= 28; i++) expv[i] = pat[(i - 1) / 4];
          chk("frame_tx", 32'(txrec), 32'(expv));
          chk("frame_done_cyc", 32'(idx), 32'd28);
          chk("frame_busy", 32'(busyrec), 32'h1FFF_FFFE);
          frames_seen++;
          rec = 1'b0;
        end
      end
    end
  end

  task automatic push_word(input logic [3:0] v);
    fmem[wr_ptr] = v;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_seen < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("wait_frames", 32'(frames_seen), 32'(target));
  endtask

  task automatic wait_pops(input int target);
    int n = 0;
    while (pop_log.size() < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_pops", 32'(pop_log.size()), 32'(target));
  endtask

  initial begin
    int viol;
    tests = 0; fails = 0; cyc = 0; frames_seen = 0;
    rec = 1'b0; idx = 0; pop_pend = 1'b0;
    rd_ptr = '0; wr_ptr = '0;
    rst_n = 1'b0; en = 1'b0;
    for (int i = 0; i < 16; i++) fmem[i] = '0;

    // Reset held with a word waiting and en toggling randomly
    push_word(4'hA);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      en = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("reset_outs",
          {20'd0, ifc.tx, ifc.busy, ifc.fifo_rinc, ifc.frame_done, ifc.words_sent},
          32'h800);
    end

    // Single frame 0xA: start 0 | 0,1,0,1 | parity 0 | stop 1
    exp_q.push_back(7'b1010100);
    @(posedge clk); #2;
    en = 1'b1; rst_n = 1'b1;
    wait_frames(1);
    repeat (2) @(negedge clk);
    chk("a_pops", 32'(pop_log.size()), 32'd1);
    chk("a_words", 32'(ifc.words_sent), 32'd1);
    chk("a_busy", {31'd0, ifc.busy}, 32'd0);
    chk("a_fifo_empty", {31'd0, ifc.fifo_empty}, 32'd1);

    // Enabled with an empty FIFO for 100 cycles
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifc.fifo_rinc || !ifc.tx || ifc.busy) viol++;
    end
    chk("empty_idle_viol", 32'(viol), 32'd0);

    // Three queued words 0x1, 0x7, 0xF: parity 1, 1, 0
    @(posedge clk); #2;
    en = 1'b0;
    pop_log.delete();
    exp_q.push_back(7'b1100010);
    exp_q.push_back(7'b1101110);
    exp_q.push_back(7'b1011110);
    push_word(4'h1); push_word(4'h7); push_word(4'hF);
    @(posedge clk); #2;
    en = 1'b1;
    wait_frames(4);
    repeat (3) @(negedge clk);
    chk("q3_pops", 32'(pop_log.size()), 32'd3);
    if (pop_log.size() == 3) begin
      chk("q3_gap0", 32'(pop_log[1] - pop_log[0]), 32'd29);
      chk("q3_gap1", 32'(pop_log[2] - pop_log[1]), 32'd29);
    end
    chk("q3_words", 32'(ifc.words_sent), 32'd4);
    chk("q3_idle", {30'd0, ifc.busy, ifc.fifo_rinc}, 32'd0);

    // en dropped during DATA of 0xC with 0x3 queued behind it
    @(posedge clk); #2;
    en = 1'b0;
    pop_log.delete();
    exp_q.push_back(7'b1011000);
    push_word(4'hC); push_word(4'h3);
    @(posedge clk); #2;
    en = 1'b1;
    wait_pops(1);
    repeat (10) @(negedge clk);
    @(posedge clk); #2;
    en = 1'b0;
    wait_frames(5);
    repeat (40) @(negedge clk);
    chk("endrop_pops", 32'(pop_log.size()), 32'd1);
    chk("endrop_words", 32'(ifc.words_sent), 32'd5);
    chk("endrop_left", 32'(wr_ptr - rd_ptr), 32'd1);
    @(posedge clk); #2;
    rd_ptr = rd_ptr + 4'd1;

    // Reset pulsed during DATA bit 2 of an aborted 0x6 frame
    pop_log.delete();
    push_word(4'h6);
    en = 1'b1;
    wait_pops(1);
    repeat (13) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", {30'd0, ifc.tx, ifc.busy}, 32'd2);
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    pop_log.delete();
    repeat (20) @(negedge clk);
    chk("rst_no_pop", 32'(pop_log.size()), 32'd0);
    chk("rst_words", 32'(ifc.words_sent), 32'd0);

    // Clean frame 0x5 after reset: 0 | 1,0,1,0 | 0 | 1
    exp_q.push_back(7'b1001010);
    @(posedge clk); #2;
    push_word(4'h5);
    wait_frames(6);
    repeat (2) @(negedge clk);
    chk("post_rst_words", 32'(ifc.words_sent), 32'd1);
    chk("post_rst_pops", 32'(pop_log.size()), 32'd1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
